csa_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-skip adder/subtractor. Successor to the team's 4-bit single-block carry-skip adder.
- The operand width is split into NBLK = WIDTH/BLOCK ripple blocks. Each block has a skip mux driven by the AND of its propagate bits.
- One block is resolved per pipeline stage, with a valid/ready handshake on both sides.
- Sits in the datapath wherever wide add/sub results are needed at full throughput.

---
 rtl/csa_pipe_adder.sv | 138 +++++++++++++
 tb/tb_csa_pipe_adder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: pipelined carry-skip adder/subtractor.
//
// The operands are split into WIDTH/BLOCK ripple blocks. Each pipeline stage
// resolves one block. A block whose propagate bits are all 1 takes its
// carry-out from the skip path, which is its own carry-in. Stalls are global:
// the whole pipe advances only when the output register is empty or being
// drained.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operand beat handshake (in_ready = advance)
//   a, b, cin, sub        operands; sub=1 computes a - b and ignores cin
//   out_valid / out_ready result beat handshake
//   sum, cout, ovf        result mod 2^WIDTH, carry out, signed overflow
//   skip_mask             bit k set when block k's carry came from the skip path

module csa_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     cin,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sum,
  output logic                     cout,
  output logic                     ovf,
  output logic [WIDTH/BLOCK-1:0]   skip_mask
);

  localparam int unsigned NBLK = WIDTH / BLOCK;

  // Chain element k is the input of stage k; element k+1 is its register.
  logic             ch_v  [NBLK+1];
  logic [WIDTH-1:0] ch_p  [NBLK+1];
  logic [WIDTH-1:0] ch_s  [NBLK+1];
  logic             ch_c  [NBLK+1];
  logic [NBLK-1:0]  ch_m  [NBLK+1];
  // Operands are only needed up to the input of the last stage.
  logic [WIDTH-1:0] ch_a  [NBLK];
  logic [WIDTH-1:0] ch_bb [NBLK];

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Operand preparation at capture.
  assign ch_v[0]  = in_valid;
  assign ch_a[0]  = a;
  assign ch_bb[0] = sub ? ~b : b;
  assign ch_p[0]  = a ^ (sub ? ~b : b);
  assign ch_s[0]  = '0;
  assign ch_c[0]  = sub ? 1'b1 : cin;
  assign ch_m[0]  = '0;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    localparam int unsigned LO = k * BLOCK;

    logic [BLOCK-1:0] pb;
    logic [BLOCK:0]   rip;
    logic             c_next;
    logic [WIDTH-1:0] s_next;
    logic [NBLK-1:0]  m_next;

    logic             v_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic [NBLK-1:0]  m_q;

    always_comb begin
      pb     = ch_p[k][LO +: BLOCK];
      rip    = {1'b0, ch_a[k][LO +: BLOCK]} + {1'b0, ch_bb[k][LO +: BLOCK]}
             + {{BLOCK{1'b0}}, ch_c[k]};
      c_next = (&pb) ? ch_c[k] : rip[BLOCK];
      s_next = ch_s[k];
      s_next[LO +: BLOCK] = rip[BLOCK-1:0];
      m_next    = ch_m[k];
      m_next[k] = &pb;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        p_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        m_q <= '0;
      end else if (advance) begin
        v_q <= ch_v[k];
        p_q <= ch_p[k];
        s_q <= s_next;
        c_q <= c_next;
        m_q <= m_next;
      end
    end

    assign ch_v[k+1] = v_q;
    assign ch_p[k+1] = p_q;
    assign ch_s[k+1] = s_q;
    assign ch_c[k+1] = c_q;
    assign ch_m[k+1] = m_q;

    if (k < NBLK - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] bb_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q  <= '0;
          bb_q <= '0;
        end else if (advance) begin
          a_q  <= ch_a[k];
          bb_q <= ch_bb[k];
        end
      end

      assign ch_a[k+1]  = a_q;
      assign ch_bb[k+1] = bb_q;
    end
  end

  assign out_valid = ch_v[NBLK];
  assign sum       = ch_s[NBLK];
  assign cout      = ch_c[NBLK];
  assign skip_mask = ch_m[NBLK];
  // Carry into the MSB is recovered as sum[MSB] ^ p[MSB] from the final
  // register, so ovf is a pure function of held state and stays stable.
  assign ovf       = ch_s[NBLK][WIDTH-1] ^ ch_p[NBLK][WIDTH-1] ^ ch_c[NBLK];

endmodule

// File: tb/tb_csa_pipe_adder.sv
module tb_csa_pipe_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned BLOCK = 4;
  localparam int unsigned NBLK  = WIDTH / BLOCK;
  localparam int unsigned NRAND = 2000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [NBLK-1:0]  skip_mask;

  always #5 clk = ~clk;

  csa_pipe_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .skip_mask(skip_mask)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  mask;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rx     = 0;
  logic hold_pend = 1'b0;
  res_t held;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide addition; overflow from operand/result signs.
  function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mcin, input logic msub);
    logic [15:0] mbb;
    logic [15:0] pp;
    logic [16:0] t;
    res_t        r;
    mbb    = msub ? ~mb : mb;
    t      = {1'b0, ma} + {1'b0, mbb} + {16'b0, (msub | mcin)};
    pp     = ma ^ mbb;
    r.sum  = t[15:0];
    r.cout = t[16];
    r.ovf  = (ma[15] == mbb[15]) && (t[15] != ma[15]);
    for (int k = 0; k < 4; k++) r.mask[k] = (pp[4*k +: 4] == 4'hF);
    return r;
  endfunction

  // Scoreboard and output-stability monitor, sampled away from the clock edge.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        check_eq("hold", 32'({sum, cout, ovf, skip_mask}), 32'(held));
      hold_pend = out_valid && !out_ready;
      held      = {sum, cout, ovf, skip_mask};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_beat", 32'(out_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("sb.sum",  32'(sum),       32'(e.sum));
          check_eq("sb.cout", 32'(cout),      32'(e.cout));
          check_eq("sb.ovf",  32'(ovf),       32'(e.ovf));
          check_eq("sb.mask", 32'(skip_mask), 32'(e.mask));
          n_rx++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic dir_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vcin, input logic vsub, input logic [15:0] es,
                         input logic ec, input logic eo, input logic [3:0] em);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; a = va; b = vb; cin = vcin; sub = vsub; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check_eq({tag, ".lat"},  32'(lat),       32'(NBLK));
    check_eq({tag, ".sum"},  32'(sum),       32'(es));
    check_eq({tag, ".cout"}, 32'(cout),      32'(ec));
    check_eq({tag, ".ovf"},  32'(ovf),       32'(eo));
    check_eq({tag, ".mask"}, 32'(skip_mask), 32'(em));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent;
    int rx;
    int last;
    int rx0;
    int cycles;
    logic [15:0] corner [5];

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst.out_valid", 32'(out_valid), 32'(0));
    check_eq("rst.in_ready",  32'(in_ready),  32'(1));
    check_eq("rst.sum",       32'(sum),       32'(0));
    check_eq("rst.mask",      32'(skip_mask), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors, expected values worked by hand.
    dir_vec("add",     16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4'h0);
    dir_vec("addskip", 16'h1234, 16'hEDCB, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'hF);
    dir_vec("cin",     16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 4'h3);
    dir_vec("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'hE);
    dir_vec("ovfpos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'h6);
    dir_vec("sub",     16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'hE);
    dir_vec("subovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'h6);

    // Reset mid-stream: fill the pipe under backpressure, then reset.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 16'(16'h0111 + i * 16'h0101); b = 16'h0100; cin = 1'b1; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("prerst.out_valid", 32'(out_valid), 32'(1));
    check_eq("prerst.sum",       32'(sum),       32'(16'h0212));
    #2 rst = 1'b1;
    #1;
    check_eq("midrst.out_valid", 32'(out_valid), 32'(0));
    check_eq("midrst.sum",       32'(sum),       32'(0));
    check_eq("midrst.cout",      32'(cout),      32'(0));
    check_eq("midrst.ovf",       32'(ovf),       32'(0));
    check_eq("midrst.mask",      32'(skip_mask), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("postrst.out_valid", 32'(out_valid), 32'(0));
    end

    // Back-to-back stream of 8 beats with a 4-cycle output stall.
    @(posedge clk); #1;
    sent = 0; rx = 0; last = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid  = (sent < 8);
      a = 16'(sent + 1); b = 16'(2 * (sent + 1)); cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      if (cyc >= 4 && cyc <= 7) begin
        check_eq("stall.in_ready",  32'(in_ready),  32'(0));
        check_eq("stall.out_valid", 32'(out_valid), 32'(1));
        check_eq("stall.sum",       32'(sum),       32'(3));
      end
      if (out_valid && out_ready) begin
        check_eq("stream.sum", 32'(sum), 32'(3 * (rx + 1)));
        rx++;
        last = cyc;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("stream.count", 32'(rx),   32'(8));
    check_eq("stream.last",  32'(last), 32'(15));

    // Random traffic with corner operands mixed in.
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'h0001;
    sent = 0; rx0 = n_rx; cycles = 0;
    while ((n_rx - rx0) < int'(NRAND) && cycles < 20000) begin
      in_valid  = (sent < int'(NRAND)) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rand.count", 32'(n_rx - rx0),   32'(NRAND));
    check_eq("rand.drain", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
